// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and defaults for the two-master Wishbone
//               arbiter and its bus watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Arbiter state: idle, or granted to master 0 / master 1
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   localparam int DEFAULT_ADDR_WIDTH = 32;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int WD_WIDTH           = 16;

   // One-hot grant vector for the debug LEDs; 2'b00 while idle
   function automatic logic [1:0] grant_onehot(input state_t st);
      grant_onehot = {st == ST_G1, st == ST_G0};
   endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter2_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2_if
// Description : Bundle of both master ports, the slave port and the grant
//               debug vector of the two-master Wishbone arbiter.
//               'slave' is the arbiter's view, 'master' the surrounding
//               system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter2_if
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   // master 0
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic [DATA_WIDTH-1:0] m0_data_i;
   logic                  m0_cyc_i;
   logic                  m0_stb_i;
   logic                  m0_we_i;
   logic [DATA_WIDTH-1:0] m0_data_o;
   logic                  m0_ack_o;
   logic                  m0_err_o;

   // master 1
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic [DATA_WIDTH-1:0] m1_data_i;
   logic                  m1_cyc_i;
   logic                  m1_stb_i;
   logic                  m1_we_i;
   logic [DATA_WIDTH-1:0] m1_data_o;
   logic                  m1_ack_o;
   logic                  m1_err_o;

   // shared slave
   logic [ADDR_WIDTH-1:0] s_addr_o;
   logic [DATA_WIDTH-1:0] s_data_o;
   logic                  s_cyc_o;
   logic                  s_stb_o;
   logic                  s_we_o;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  s_ack_i;

   logic [1:0]            grant_o;

   modport slave (
      input  m0_addr_i, m0_data_i, m0_cyc_i, m0_stb_i, m0_we_i,
      output m0_data_o, m0_ack_o, m0_err_o,
      input  m1_addr_i, m1_data_i, m1_cyc_i, m1_stb_i, m1_we_i,
      output m1_data_o, m1_ack_o, m1_err_o,
      output s_addr_o, s_data_o, s_cyc_o, s_stb_o, s_we_o,
      input  s_data_i, s_ack_i,
      output grant_o
   );

   modport master (
      output m0_addr_i, m0_data_i, m0_cyc_i, m0_stb_i, m0_we_i,
      input  m0_data_o, m0_ack_o, m0_err_o,
      output m1_addr_i, m1_data_i, m1_cyc_i, m1_stb_i, m1_we_i,
      input  m1_data_o, m1_ack_o, m1_err_o,
      input  s_addr_o, s_data_o, s_cyc_o, s_stb_o, s_we_o,
      output s_data_i, s_ack_i,
      input  grant_o
   );

endinterface : wb_arbiter2_if
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Bus watchdog. Counts strobed cycles without ack and emits a
//               registered one-cycle err pulse on the cycle that would be
//               the TIMEOUT_CYCLES-th such cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic active,   // strobed cycle on the slave
   input  logic ack,      // slave acknowledged this cycle
   input  logic clear,    // owner changes this cycle
   output logic err
);

   // count holds the number of earlier stalled cycles, so count == LIMIT
   // in an active cycle means this is stalled cycle TIMEOUT_CYCLES-1 and the
   // next cycle must carry the error instead of another strobe.
   localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 2);

   logic [WD_WIDTH-1:0] count;
   logic                fire;

   assign fire = active && !ack && !clear && (count == LIMIT);

   // Stall counter and err pulse; ack, err and owner change restart the count
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         err   <= 1'b0;
      end else begin
         err <= fire;
         if (ack || err || clear) begin
            count <= '0;
         end else if (active) begin
            count <= count + WD_WIDTH'(1);
         end
      end
   end

endmodule : wb_watchdog
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master, one-slave Wishbone classic arbiter. Round-robin
//               on ties, grant held for the whole bus cycle, watchdog err
//               returned to the owner if the slave stops acking.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clock,
   input  logic          reset,
   wb_arbiter2_if.slave  bus
);

   state_t                state;
   state_t                state_next;
   logic                  last;         // 0: master 0 was granted last
   logic                  wd_err;
   logic                  granted_cyc;
   logic                  granted_stb;
   logic                  granted_we;
   logic [ADDR_WIDTH-1:0] granted_addr;
   logic [DATA_WIDTH-1:0] granted_data;
   logic                  slave_cyc;
   logic                  slave_stb;

   // State register and last-winner flag; reset favours master 0 on a tie
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_next;
         if (state_next == ST_G0) begin
            last <= 1'b0;
         end else if (state_next == ST_G1) begin
            last <= 1'b1;
         end
      end
   end

   // Next grant and owner mux; owner keeps the bus until its cyc drops
   always_comb begin
      state_next   = state;
      granted_cyc  = bus.m0_cyc_i;
      granted_stb  = bus.m0_stb_i;
      granted_we   = bus.m0_we_i;
      granted_addr = bus.m0_addr_i;
      granted_data = bus.m0_data_i;

      if (state == ST_G1) begin
         granted_cyc  = bus.m1_cyc_i;
         granted_stb  = bus.m1_stb_i;
         granted_we   = bus.m1_we_i;
         granted_addr = bus.m1_addr_i;
         granted_data = bus.m1_data_i;
      end

      case (state)
         ST_IDLE: begin
            if (bus.m0_cyc_i && bus.m1_cyc_i) begin
               state_next = last ? ST_G0 : ST_G1;
            end else if (bus.m0_cyc_i) begin
               state_next = ST_G0;
            end else if (bus.m1_cyc_i) begin
               state_next = ST_G1;
            end
         end
         ST_G0: begin
            if (!bus.m0_cyc_i) begin
               state_next = bus.m1_cyc_i ? ST_G1 : ST_IDLE;
            end
         end
         ST_G1: begin
            if (!bus.m1_cyc_i) begin
               state_next = bus.m0_cyc_i ? ST_G0 : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign slave_cyc = (state != ST_IDLE) && granted_cyc;
   assign slave_stb = slave_cyc && granted_stb && !wd_err;

   wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .active (slave_cyc && slave_stb),
      .ack    (bus.s_ack_i),
      .clear  (state_next != state),
      .err    (wd_err)
   );

   assign bus.s_addr_o  = granted_addr;
   assign bus.s_data_o  = granted_data;
   assign bus.s_we_o    = slave_cyc && granted_we;
   assign bus.s_cyc_o   = slave_cyc;
   assign bus.s_stb_o   = slave_stb;

   assign bus.m0_ack_o  = bus.s_ack_i && (state == ST_G0);
   assign bus.m1_ack_o  = bus.s_ack_i && (state == ST_G1);
   assign bus.m0_err_o  = wd_err && (state == ST_G0);
   assign bus.m1_err_o  = wd_err && (state == ST_G1);
   assign bus.m0_data_o = (state == ST_G0) ? bus.s_data_i : '0;
   assign bus.m1_data_o = (state == ST_G1) ? bus.s_data_i : '0;

   assign bus.grant_o   = grant_onehot(state);

endmodule : wb_arbiter2
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Directed self-checking bench for wb_arbiter2 with an
//               8-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   wb_arbiter2_if bus ();

   wb_arbiter2 #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drop_all();
      bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
      bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
      bus.s_ack_i  = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.m0_addr_i = '0; bus.m0_data_i = '0;
      bus.m1_addr_i = '0; bus.m1_data_i = '0;
      bus.s_data_i  = '0;
      drop_all();
      tick(); tick();
      reset = 1'b0;
      #1;

      // reset values
      chk("rst_grant", bus.grant_o, 2'b00);
      chk("rst_scyc",  bus.s_cyc_o, 0);
      chk("rst_sstb",  bus.s_stb_o, 0);
      chk("rst_swe",   bus.s_we_o, 0);
      chk("rst_acks",  {bus.m0_ack_o, bus.m1_ack_o}, 0);
      chk("rst_errs",  {bus.m0_err_o, bus.m1_err_o}, 0);

      // single m0 write to 0x10, acked one cycle after grant
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
      bus.m0_addr_i = 32'h10; bus.m0_data_i = 32'hCAFE_0001;
      #1;
      chk("t1_grant_pre", bus.grant_o, 2'b00);
      chk("t1_scyc_pre",  bus.s_cyc_o, 0);
      tick();
      chk("t1_grant",  bus.grant_o, 2'b01);
      chk("t1_scyc",   bus.s_cyc_o, 1);
      chk("t1_sstb",   bus.s_stb_o, 1);
      chk("t1_swe",    bus.s_we_o, 1);
      chk("t1_saddr",  bus.s_addr_o, 32'h10);
      chk("t1_sdata",  bus.s_data_o, 32'hCAFE_0001);
      chk("t1_m0ack0", bus.m0_ack_o, 0);
      bus.s_ack_i = 1; bus.s_data_i = 32'h1234_5678;
      #1;
      chk("t1_m0ack",  bus.m0_ack_o, 1);
      chk("t1_m1ack",  bus.m1_ack_o, 0);
      chk("t1_m0data", bus.m0_data_o, 32'h1234_5678);
      chk("t1_m1data", bus.m1_data_o, 0);
      tick();
      drop_all();
      #1;
      chk("t1_drop_scyc",  bus.s_cyc_o, 0);
      chk("t1_drop_grant", bus.grant_o, 2'b01);
      tick();
      chk("t1_idle", bus.grant_o, 2'b00);

      // three simultaneous requests after reset: G0, G1, G0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
         bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
         tick();
         chk($sformatf("t2_grant_%0d", r), bus.grant_o, (r == 1) ? 2'b10 : 2'b01);
         chk($sformatf("t2_scyc_%0d", r), bus.s_cyc_o, 1);
         drop_all();
         tick();
         chk($sformatf("t2_idle_%0d", r), bus.grant_o, 2'b00);
      end

      // m1 holds a 10-cycle acked burst while m0 waits; handover without idle
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_addr_i = 32'h20;
      bus.s_ack_i = 1;
      tick();
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'h10;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t3_grant_%0d", i), bus.grant_o, 2'b10);
         chk($sformatf("t3_m1ack_%0d", i), bus.m1_ack_o, 1);
         chk($sformatf("t3_m0ack_%0d", i), bus.m0_ack_o, 0);
         chk($sformatf("t3_saddr_%0d", i), bus.s_addr_o, 32'h20);
         tick();
      end
      bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.s_ack_i = 0;
      #1;
      chk("t3_m1drop_scyc",  bus.s_cyc_o, 0);
      chk("t3_m1drop_grant", bus.grant_o, 2'b10);
      tick();
      chk("t3_handover", bus.grant_o, 2'b01);
      chk("t3_saddr_m0", bus.s_addr_o, 32'h10);
      drop_all();
      tick();
      chk("t3_idle", bus.grant_o, 2'b00);

      // slave never acks: err on strobed cycle 8, then again 8 cycles later
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0;
      tick();
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 1; k <= 7; k++) begin
            #1;
            chk($sformatf("t4_err0_p%0d_c%0d", pass, k), bus.m0_err_o, 0);
            chk($sformatf("t4_stb1_p%0d_c%0d", pass, k), bus.s_stb_o, 1);
            tick();
         end
         chk($sformatf("t4_err_p%0d", pass), bus.m0_err_o, 1);
         chk($sformatf("t4_stbmask_p%0d", pass), bus.s_stb_o, 0);
         chk($sformatf("t4_m1err_p%0d", pass), bus.m1_err_o, 0);
         chk($sformatf("t4_scyc_p%0d", pass), bus.s_cyc_o, 1);
         tick();
      end
      chk("t4_after_err", bus.m0_err_o, 0);
      drop_all();
      tick();
      chk("t4_idle", bus.grant_o, 2'b00);

      // ack on stalled cycle 7 beats the timeout
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         #1;
         chk($sformatf("t5_err0_c%0d", k), bus.m0_err_o, 0);
         tick();
      end
      bus.s_ack_i = 1;
      #1;
      chk("t5_ack",  bus.m0_ack_o, 1);
      chk("t5_err7", bus.m0_err_o, 0);
      tick();
      bus.s_ack_i = 0;
      #1;
      chk("t5_err8", bus.m0_err_o, 0);
      chk("t5_stb8", bus.s_stb_o, 1);
      drop_all();
      tick();

      // reset while m1 is mid-read; late ack ignored; next tie goes to m0
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_addr_i = 32'h30;
      tick();
      chk("t6_grant_g1", bus.grant_o, 2'b10);
      reset = 1'b1;
      bus.s_ack_i = 1;
      tick();
      reset = 1'b0;
      #1;
      chk("t6_scyc",  bus.s_cyc_o, 0);
      chk("t6_sstb",  bus.s_stb_o, 0);
      chk("t6_grant", bus.grant_o, 2'b00);
      chk("t6_m1ack", bus.m1_ack_o, 0);
      bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
      bus.s_ack_i = 0;
      tick();
      chk("t6_tie_m0", bus.grant_o, 2'b01);
      drop_all();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wb_arbiter2
`default_nettype wire

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter placed in front of wb_system.
- Lets uart_wb_master (master 0) and a second on-chip master (master 1, e.g. a debug/boot loader) share the single slave port.
- Fair round-robin grant, held for the whole bus cycle (cyc high).
- Bus watchdog returns err to the granted master when the slave fails to ack, so a hung slave cannot lock the UART host out.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 255, strobed cycles without ack before err is issued; legal range 2..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_addr_i  in  ADDR_WIDTH  master 0 address.
- m0_data_i  in  DATA_WIDTH  master 0 write data.
- m0_cyc_i  in  1  master 0 cycle.
- m0_stb_i  in  1  master 0 strobe.
- m0_we_i  in  1  master 0 write enable.
- m0_data_o  out  DATA_WIDTH  read data to master 0.
- m0_ack_o  out  1  ack to master 0.
- m0_err_o  out  1  timeout error to master 0.
- m1_addr_i, m1_data_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_data_o, m1_ack_o, m1_err_o: identical set for master 1.
- s_addr_o  out  ADDR_WIDTH  address to slave.
- s_data_o  out  DATA_WIDTH  write data to slave.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_data_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  2  one-hot current grant, for debug LEDs; 00 when idle.

Behaviour:
- Registered FSM with states IDLE, G0, G1; last-winner flag `last` (0 = master 0 was granted last).
- Reset: state IDLE, last=1 so master 0 wins the first tie. err pulse cleared, watchdog counter 0.
- Reset values of outputs: s_cyc_o=0, s_stb_o=0, s_we_o=0, all m*_ack_o=0, all m*_err_o=0, grant_o=00. Data/address outputs are don't-care at reset and must not be X-dependent on the FSM.
- IDLE transitions:
  - only m0_cyc → G0; only m1_cyc → G1.
  - both → the master other than `last`.
  - none → stay.
- Grant latency: one cycle from cyc assertion to the slave seeing cyc/stb.
- Entering Gn sets last=n.
- Gn with mn_cyc_i high: stay. A request from the other master never pre-empts.
- Gn with mn_cyc_i low: go to G(other) if the other cyc is high, else IDLE. No idle bubble is required.
- Slave-side signals:
  - s_addr/data/we = granted master's signals, muxed from registered state.
  - s_cyc_o = state!=IDLE && granted cyc.
  - s_stb_o = s_cyc_o && granted stb && !wd_err.
- Master-side signals:
  - m_n_ack_o = s_ack_i && state==Gn (combinational).
  - m_n_data_o = s_data_i when granted, else 0.
  - A non-granted master never sees ack or err.
- Watchdog:
  - 16-bit counter increments each cycle s_cyc_o && s_stb_o && !s_ack_i.
  - Clears on ack, on err, and on any state change.
  - When count == TIMEOUT_CYCLES-1 and no ack in that cycle, wd_err is set. It is a registered, exactly one-cycle pulse on the granted master's err_o, and s_stb_o is masked during that cycle.
- Ack and timeout in the same cycle: ack wins, no err.
- Master dropping cyc mid-transfer: the slave sees cyc fall the same cycle, and the counter clears at the state change.
- Reset asserted mid-transfer: next cycle is IDLE with all outputs at reset values; any late slave ack is ignored.

Decomposition:
- Shared package wb_pkg:
  - state encoding constants ST_IDLE, ST_G0, ST_G1.
  - default widths.
- One natural sub-module, wb_watchdog (counter + err pulse, inputs active/ack/clear, output err), reusable for a future UART-side timeout.

Test Plan:
- After reset, m0 write to addr 0x10, slave acks 1 cycle later. Required: grant_o=01 one cycle after m0_cyc, m0_ack_o high, m1_ack_o=0.
- m0_cyc and m1_cyc rise the same cycle, three times in succession. Required: grants in order G0, G1, G0.
- m1 is held granted for a 10-cycle burst while m0 requests. Required: m0 is not granted until m1_cyc falls, then G0 the next cycle with no IDLE cycle.
- Slave never acks, TIMEOUT_CYCLES=8. Required: m0_err_o high exactly on strobed cycle 8, s_stb_o low that cycle, counter restarts if m0 keeps stb high.
- Slave ack on the same cycle the counter hits TIMEOUT_CYCLES-1. Required: ack delivered, err stays 0.
- Reset asserted while G1 is mid-read. Required: next cycle state IDLE, s_cyc_o=0, grant_o=00, a following simultaneous request goes to m0.
